// File: rtl/branch_resolver_pkg.sv
// Shared types and constants for the branch resolver: funct3 encodings,
// FSM state enum and the default datapath width.
package branch_resolver_pkg;

  localparam int XLEN_DEF = 32;

  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_REDIRECT = 2'd1,
    ST_FLUSH    = 2'd2
  } br_state_t;

endpackage

// File: rtl/branch_resolver_if.sv
// Branch-in / comparator / redirect-out bundle of the branch resolver.
// The slave modport is the resolver's view, master is decode/fetch/comparator.
interface branch_resolver_if #(
  parameter int XLEN = 32
);
  logic            br_valid;
  logic            br_ready;
  logic [2:0]      br_funct3;
  logic [XLEN-1:0] br_pc;
  logic [XLEN-1:0] br_imm;
  logic            cmp_signed;
  logic            cmp_eq;
  logic            cmp_lt;
  logic            redir_valid;
  logic            redir_ready;
  logic [XLEN-1:0] redir_pc;
  logic            flush;
  logic            br_illegal;
  logic            br_misaligned;

  modport slave (
    input  br_valid, br_funct3, br_pc, br_imm, cmp_eq, cmp_lt, redir_ready,
    output br_ready, cmp_signed, redir_valid, redir_pc, flush,
           br_illegal, br_misaligned
  );

  modport master (
    output br_valid, br_funct3, br_pc, br_imm, cmp_eq, cmp_lt, redir_ready,
    input  br_ready, cmp_signed, redir_valid, redir_pc, flush,
           br_illegal, br_misaligned
  );
endinterface

// File: rtl/branch_resolver_cond.sv
// Branch condition decode: funct3 plus comparator eq/lt to taken/illegal,
// and the signed-select fed back to the comparator.
module branch_cond
  import branch_resolver_pkg::*;
(
  input  logic [2:0] i_funct3,
  input  logic       i_eq,
  input  logic       i_lt,
  output logic       o_taken,
  output logic       o_illegal,
  output logic       o_signed
);

  always_comb begin
    o_taken   = 1'b0;
    o_illegal = 1'b0;
    case (i_funct3)
      F3_BEQ:           o_taken   = i_eq;
      F3_BNE:           o_taken   = ~i_eq;
      F3_BLT, F3_BLTU:  o_taken   = i_lt;
      F3_BGE, F3_BGEU:  o_taken   = ~i_lt;
      default:          o_illegal = 1'b1;
    endcase
  end

  assign o_signed = (i_funct3 == F3_BLT) || (i_funct3 == F3_BGE);

endmodule

// File: rtl/branch_resolver.sv
// Branch resolver top: accepts a branch, redirects fetch on taken aligned targets,
// then holds flush. Optional BRANCH_STATS_EN adds saturating branch/redirect counters.
//
// state    | meaning
// IDLE     | ready for a branch; not-taken/illegal/misaligned stay here
// REDIRECT | redir_valid + flush high, redir_pc held until fetch accepts
// FLUSH    | flush high while the counter runs down to 0
module branch_resolver
  import branch_resolver_pkg::*;
#(
  parameter int XLEN         = XLEN_DEF,
  parameter int FLUSH_CYCLES = 2
)(
  input  logic               clk,
  input  logic               reset_n,
  branch_resolver_if.slave   bus
`ifdef BRANCH_STATS_EN
  ,
  output logic [31:0]        stat_branches,
  output logic [31:0]        stat_taken
`endif
);

  localparam logic [3:0] FLUSH_LOAD = 4'(FLUSH_CYCLES - 1);

  br_state_t       r_state;
  br_state_t       w_state_nxt;
  logic [3:0]      r_flush_cnt;
  logic [3:0]      w_flush_cnt_nxt;
  logic [XLEN-1:0] r_redir_pc;
  logic [XLEN-1:0] w_target;
  logic            r_illegal;
  logic            r_misaligned;
  logic            w_taken;
  logic            w_illegal;
  logic            w_signed;
  logic            w_accept;
  logic            w_redirect;
  logic            w_handshake;

  branch_cond u_cond (
    .i_funct3  (bus.br_funct3),
    .i_eq      (bus.cmp_eq),
    .i_lt      (bus.cmp_lt),
    .o_taken   (w_taken),
    .o_illegal (w_illegal),
    .o_signed  (w_signed)
  );

  assign w_accept   = bus.br_valid && (r_state == ST_IDLE);
  assign w_target   = bus.br_pc + bus.br_imm;
  assign w_redirect = w_accept && w_taken && !w_target[1];

  always_comb begin
    w_state_nxt     = r_state;
    w_flush_cnt_nxt = r_flush_cnt;
    w_handshake     = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_redirect) w_state_nxt = ST_REDIRECT;
      end
      ST_REDIRECT: begin
        if (bus.redir_ready) begin
          w_handshake     = 1'b1;
          w_state_nxt     = ST_FLUSH;
          w_flush_cnt_nxt = FLUSH_LOAD;
        end
      end
      ST_FLUSH: begin
        if (r_flush_cnt == 4'd0) w_state_nxt = ST_IDLE;
        else                     w_flush_cnt_nxt = r_flush_cnt - 4'd1;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state      <= ST_IDLE;
      r_flush_cnt  <= 4'd0;
      r_redir_pc   <= '0;
      r_illegal    <= 1'b0;
      r_misaligned <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_flush_cnt  <= w_flush_cnt_nxt;
      r_illegal    <= w_accept && w_illegal;
      r_misaligned <= w_accept && w_taken && w_target[1];
      if (w_redirect) r_redir_pc <= w_target;
    end
  end

  assign bus.br_ready      = (r_state == ST_IDLE);
  assign bus.redir_valid   = (r_state == ST_REDIRECT);
  assign bus.flush         = (r_state != ST_IDLE);
  assign bus.redir_pc      = r_redir_pc;
  assign bus.cmp_signed    = w_signed;
  assign bus.br_illegal    = r_illegal;
  assign bus.br_misaligned = r_misaligned;

`ifdef BRANCH_STATS_EN
  logic [31:0] r_stat_branches;
  logic [31:0] r_stat_taken;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_stat_branches <= '0;
      r_stat_taken    <= '0;
    end else begin
      if (w_accept && (r_stat_branches != 32'hFFFF_FFFF))
        r_stat_branches <= r_stat_branches + 32'd1;
      if (w_handshake && (r_stat_taken != 32'hFFFF_FFFF))
        r_stat_taken <= r_stat_taken + 32'd1;
    end
  end

  assign stat_branches = r_stat_branches;
  assign stat_taken    = r_stat_taken;
`endif

endmodule
